// File: rtl/bist_sequencer.sv
// Sequencing FSM for the arbiter BIST session: INIT, RUN for N_PATTERNS clocks,
// FLUSH, COMPARE against a golden MISR signature, then hold the verdict in DONE.
module bist_sequencer #(
    parameter int unsigned       N_PATTERNS = 1000,
    parameter int unsigned       CNT_W      = 16,
    parameter int unsigned       SIG_W      = 16,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             test_mode,
    output logic             lfsr_init,
    output logic             lfsr_en,
    output logic             misr_init,
    output logic             misr_en,
    output logic             cut_reset_n,
    output logic             busy,
    output logic             bist_end,
    output logic             pass_fail
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             init_phase, init_phase_next;
    logic             test_mode_next, lfsr_init_next, lfsr_en_next;
    logic             misr_init_next, misr_en_next, cut_reset_n_next;
    logic             busy_next, bist_end_next, pass_fail_next;

    // State, counters and registered Moore outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            init_phase  <= 1'b0;
            test_mode   <= 1'b0;
            lfsr_init   <= 1'b0;
            lfsr_en     <= 1'b0;
            misr_init   <= 1'b0;
            misr_en     <= 1'b0;
            cut_reset_n <= 1'b1;
            busy        <= 1'b0;
            bist_end    <= 1'b0;
            pass_fail   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            init_phase  <= init_phase_next;
            test_mode   <= test_mode_next;
            lfsr_init   <= lfsr_init_next;
            lfsr_en     <= lfsr_en_next;
            misr_init   <= misr_init_next;
            misr_en     <= misr_en_next;
            cut_reset_n <= cut_reset_n_next;
            busy        <= busy_next;
            bist_end    <= bist_end_next;
            pass_fail   <= pass_fail_next;
        end
    end

    // Next-state logic, then outputs decoded from the next state
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        init_phase_next  = init_phase;
        pass_fail_next   = 1'b0;
        test_mode_next   = 1'b0;
        lfsr_init_next   = 1'b0;
        lfsr_en_next     = 1'b0;
        misr_init_next   = 1'b0;
        misr_en_next     = 1'b0;
        cut_reset_n_next = 1'b1;
        busy_next        = 1'b0;
        bist_end_next    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next      = S_INIT;
                    cnt_next        = '0;
                    init_phase_next = 1'b0;
                end
            end
            S_INIT: begin
                cnt_next = '0;
                if (init_phase) begin
                    state_next = S_RUN;
                end else begin
                    init_phase_next = 1'b1;
                end
            end
            S_RUN: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_next = S_COMPARE;
            end
            S_COMPARE: begin
                state_next     = S_DONE;
                pass_fail_next = (misr_sig == GOLDEN_SIG);
            end
            S_DONE: begin
                // Verdict is held until start drops, which forces a fresh rise per session
                if (!start) begin
                    state_next = S_IDLE;
                end else begin
                    pass_fail_next = pass_fail;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_INIT: begin
                test_mode_next   = 1'b1;
                lfsr_init_next   = 1'b1;
                misr_init_next   = 1'b1;
                cut_reset_n_next = 1'b0;
                busy_next        = 1'b1;
            end
            S_RUN: begin
                test_mode_next = 1'b1;
                lfsr_en_next   = 1'b1;
                misr_en_next   = 1'b1;
                busy_next      = 1'b1;
            end
            S_FLUSH: begin
                // Grant lags its request by one cycle, so the MISR takes one extra sample
                test_mode_next = 1'b1;
                misr_en_next   = 1'b1;
                busy_next      = 1'b1;
            end
            S_COMPARE: begin
                test_mode_next = 1'b1;
                busy_next      = 1'b1;
            end
            S_DONE: begin
                bist_end_next = 1'b1;
            end
            default: begin
                bist_end_next = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/bist_sequencer.md
# bist_sequencer

Sequencing FSM for the arbiter BIST session. It drives the LFSR pattern generator, the MISR response compactor, the input-select mux in front of the four-requester arbiter under test, and the arbiter's reset. It runs a fixed-length session of `N_PATTERNS` clocks, then compares the final MISR signature against a golden value. It reports `bist_end` and `pass_fail` at the top level.

## Interface
Parameters:
- `N_PATTERNS`, default 1000: number of RUN cycles (pattern clocks); legal range 1 .. 2^CNT_W.
- `CNT_W`, default 16: pattern counter width.
- `SIG_W`, default 16: MISR signature width.
- `GOLDEN_SIG`, default 16'h0000: expected fault-free signature, SIG_W bits.

Ports:
- `clock`, in, 1: single system clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset; it forces IDLE and the output reset values immediately.
- `start`, in, 1: session request, level-sensitive, sampled only in IDLE.
- `misr_sig`, in, SIG_W: current MISR signature.
- `test_mode`, out, 1: 1 = arbiter `request1..4` sourced from LFSR; 0 = functional inputs.
- `lfsr_init`, out, 1: load LFSR seed.
- `lfsr_en`, out, 1: advance LFSR one step.
- `misr_init`, out, 1: clear MISR.
- `misr_en`, out, 1: compact `grant_o` into MISR.
- `cut_reset_n`, out, 1: active-low reset to the arbiter under test; the top ANDs it with `reset`.
- `busy`, out, 1: session in progress (INIT through COMPARE).
- `bist_end`, out, 1: session complete.
- `pass_fail`, out, 1: 1 = signature matched; valid only while `bist_end`=1.

## Operation
- All outputs are registered Moore outputs, decoded from the next state.
- States:
  - IDLE
  - INIT (2 cycles, sub-counter)
  - RUN (N_PATTERNS cycles)
  - FLUSH (1 cycle)
  - COMPARE (1 cycle)
  - DONE
- IDLE:
  - all controls 0, `cut_reset_n`=1, `bist_end`=0.
  - `start`=1 at an edge → INIT.
- INIT:
  - `test_mode`=1, `lfsr_init`=1, `misr_init`=1, `cut_reset_n`=0, `busy`=1.
  - Pattern counter cleared to 0.
  - After the 2nd cycle → RUN.
- RUN:
  - `test_mode`=1, `lfsr_en`=1, `misr_en`=1, `cut_reset_n`=1.
  - Counter increments each cycle.
  - The cycle with counter = N_PATTERNS-1 is the last RUN cycle → FLUSH.
  - Compare the counter at CNT_W bits; no overflow occurs for legal N_PATTERNS.
- FLUSH:
  - `lfsr_en`=0, `misr_en`=1. This compacts the last registered `grant_o`, which lags its request by one cycle.
  - `test_mode` stays 1.
- COMPARE:
  - All enables 0, `test_mode`=1.
  - `pass_fail` register loads (`misr_sig` == GOLDEN_SIG).
  - → DONE.
- DONE:
  - `bist_end`=1, `pass_fail` held, `busy`=0, `test_mode`=0.
  - Stays in DONE while `start`=1. `start`=0 → IDLE; this clears `bist_end` and `pass_fail`.
  - A new session therefore requires `start` to drop and rise again.
- `start` is ignored in INIT/RUN/FLUSH/COMPARE; dropping it does not abort a session.
- Only `reset` aborts.
- Unreachable state encodings → IDLE.

## Timing
- Reset values:
  - 0: `test_mode`, `lfsr_init`, `lfsr_en`, `misr_init`, `misr_en`, `busy`, `bist_end`, `pass_fail`.
  - 1: `cut_reset_n`.
- Let edge E0 be the edge where IDLE samples `start`=1. Then:
  - INIT outputs are valid during cycles E0..E0+1.
  - RUN occupies cycles E0+2..E0+N_PATTERNS+1.
  - FLUSH is cycle E0+N_PATTERNS+2.
  - COMPARE is cycle E0+N_PATTERNS+3.
  - `bist_end`=1 from cycle E0+N_PATTERNS+4.
- Session latency from the start edge to `bist_end` is N_PATTERNS+4 cycles.
- `lfsr_en` is high for exactly N_PATTERNS cycles per session.
- `misr_en` is high for exactly N_PATTERNS+1 cycles per session.
- `misr_sig` is sampled at the end of COMPARE. It must be stable then, since `misr_en`=0 in COMPARE.
- N_PATTERNS=1: RUN lasts a single cycle, going directly INIT → RUN → FLUSH.
- Reset asserted mid-session: all outputs take their reset values asynchronously. On release the block is in IDLE, even if `start` is still high; it starts again at the first edge with `start`=1 after release.

## Test plan
- Reset, then idle: hold `reset`=0 for 3 cycles, then release with `start`=0 → all outputs at reset values and no state change for 10 cycles.
- Passing session: N_PATTERNS=8, GOLDEN_SIG=16'hA5C3, pulse `start` high 1 cycle, drive `misr_sig`=16'hA5C3 → 2 cycles of init/`cut_reset_n`=0, `lfsr_en` for 8 cycles, `misr_en` for 9 cycles, `bist_end`=1 at start edge+12, `pass_fail`=1.
- Failing session: same setup with `misr_sig`=16'hA5C2 → `bist_end`=1 at start edge+12 and `pass_fail`=0.
- Held start: keep `start`=1 throughout → DONE holds `bist_end`=1 indefinitely with no re-run. Drop `start` → IDLE next cycle with `bist_end`=0 and `pass_fail`=0. Raise it again → new INIT.
- Abort: assert `reset` in RUN at counter=4 → outputs drop to reset values asynchronously, before the next edge. After release with `start`=1 → full session from INIT, `lfsr_en` count 8.
- Minimum length: N_PATTERNS=1 → exactly 1 `lfsr_en` cycle, 2 `misr_en` cycles, `bist_end` at start edge+5.
